dsp_imem_arbiter: RTL and testbench
===================================

Name: dsp_imem_arbiter

Overview:
Owns the instruction memory port and shares it between the DSP fetch stage (PC-driven reads) and a host/loader port (reads and program writes). Sequences core run/halt/single-step by driving fetch_stall, which the fetch stage uses as a PC hold enable. Sits between the fetch block, the instruction memory and the host debug/loader interface.

Parameters:
ADDR_W, 16, instruction memory address width (matches MEM_ADDR_LEN)
INST_W, 32, instruction word width (matches INST_WORD_LEN)
BOOT_HALTED, 1, 1 = leave reset in HALTED (loader boot); 0 = leave reset in RUN

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
fetch_addr  in  ADDR_W  PC from fetch stage
fetch_data  out  INST_W  instruction to fetch stage (= mem_rdata, combinational)
fetch_stall  out  1  1 = fetch stage must hold PC this cycle
halt_req  in  1  level; 1 = host wants core halted
step_req  in  1  pulse; execute one instruction while halted
halted  out  1  1 while in HALTED
host_req  in  1  host access request, held until host_ack
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  INST_W  host write data
host_ack  out  1  one-cycle registered completion pulse
host_rdata  out  INST_W  registered read data, valid with host_ack, held until next read
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable (synchronous write)
mem_wdata  out  INST_W  memory write data
mem_rdata  in  INST_W  memory read data, combinational from mem_addr

Behaviour:
- Reset (rst=0, async): state = HALTED if BOOT_HALTED else RUN; host_ack=0, host_rdata=0, steal_block=0; pending access dropped. Combinational outputs follow the reset state.
- States: RUN, HALTED, STEP, RESUME (2-bit encoding).
- Default: mem_addr=fetch_addr, mem_we=0, mem_wdata=host_wdata, fetch_stall=0.
- Host access is "eligible" when host_req=1 and host_ack=0.
- RUN:
  - Eligible read with steal_block=0: cycle steal. mem_addr=host_addr, fetch_stall=1, host_rdata<=mem_rdata, host_ack<=1 next cycle, steal_block<=1.
  - steal_block clears after one cycle, so back-to-back steals are impossible and fetch gets at least 1 of every 2 cycles.
  - Eligible write: no action, no ack; waits for HALTED.
  - halt_req=1: next state HALTED. A steal in the same cycle still completes.
- HALTED: fetch_stall=1, halted=1.
  - Eligible access: served this cycle. Write: mem_we=1, mem_addr=host_addr. Read: capture mem_rdata. host_ack next cycle.
  - Otherwise step_req=1 -> STEP.
  - Otherwise halt_req=0 -> RESUME.
  - A host access takes priority over step/resume in the same cycle; step_req is dropped in that case.
- STEP: fetch_stall=0 for exactly one cycle (one PC advance), host not served, then HALTED.
- RESUME: fetch_stall=1, mem_addr=fetch_addr (refetch after possible rewrite), then RUN. If halt_req re-asserts during RESUME, go to HALTED instead.
- host_ack is never high two consecutive cycles.
- host_rdata is updated only on reads.
- No combinational path from host_req to host_ack.

Decomposition:
- Shared package/definitions file: ADDR_W/INST_W from MEM_ADDR_LEN/INST_WORD_LEN; state encoding constants ST_RUN=0, ST_HALTED=1, ST_STEP=2, ST_RESUME=3.
- Single module; no sub-module needed. Mux and state logic are small.

Test Plan:
- BOOT_HALTED=1, release reset, halt_req=1: halted=1, fetch_stall=1. Host write 0x0000_ABCD to addr 0x0004 -> mem_we=1 for one cycle, host_ack pulses the next cycle.
- Halted, host read addr 0x0004 -> host_ack one cycle later with host_rdata=0x0000_ABCD.
- Drop halt_req -> one RESUME cycle (fetch_stall=1, mem_addr=fetch_addr), then RUN with fetch_stall=0.
- RUN with continuous host read req (re-raised right after each ack) -> fetch_stall pattern 1,0,1,0; each read returns correct data; PC advances every second cycle.
- RUN, host write req held 5 cycles -> no ack and mem_we=0. Assert halt_req -> write completes in the first HALTED cycle, ack follows.
- Halted, step_req pulse -> exactly one cycle with fetch_stall=0, then halted=1 again. Assert rst low mid-steal -> host_ack=0 immediately, state goes to the BOOT_HALTED value.

Source files
------------

// File: rtl/dsp_imem_arbiter_pkg.sv
// rtl/dsp_imem_arbiter_pkg.sv - shared widths and state encoding for the instruction memory arbiter
package dsp_imem_arbiter_pkg;

  localparam int MEM_ADDR_LEN  = 16;
  localparam int INST_WORD_LEN = 32;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HALTED = 2'd1,
    ST_STEP   = 2'd2,
    ST_RESUME = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dsp_imem_arbiter.sv
// rtl/dsp_imem_arbiter.sv - instruction memory port arbiter between fetch and host, with run/halt/step control
module dsp_imem_arbiter
  import dsp_imem_arbiter_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_LEN,
  parameter int INST_W      = INST_WORD_LEN,
  parameter bit BOOT_HALTED = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [INST_W-1:0] fetch_data,
  output logic              fetch_stall,
  input  logic              halt_req,
  input  logic              step_req,
  output logic              halted,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [INST_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [INST_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [INST_W-1:0] mem_wdata,
  input  logic [INST_W-1:0] mem_rdata
);

  localparam arb_state_t RST_STATE = BOOT_HALTED ? ST_HALTED : ST_RUN;

  arb_state_t state;
  logic       steal_block;
  logic       eligible;
  logic       steal;
  logic       serve_rd;
  logic       serve_wr;

  // host_ack gates eligibility so a held request is not served twice
  assign eligible   = host_req && !host_ack;
  assign steal      = (state == ST_RUN) && eligible && !host_we && !steal_block;
  assign serve_wr   = (state == ST_HALTED) && eligible && host_we;
  assign serve_rd   = steal || ((state == ST_HALTED) && eligible && !host_we);

  assign fetch_data = mem_rdata;
  assign mem_wdata  = host_wdata;
  assign halted     = (state == ST_HALTED);

  always_comb begin
    mem_addr    = fetch_addr;
    mem_we      = 1'b0;
    fetch_stall = 1'b0;
    case (state)
      ST_RUN: begin
        if (steal) begin
          mem_addr    = host_addr;
          fetch_stall = 1'b1;
        end
      end
      ST_HALTED: begin
        fetch_stall = 1'b1;
        if (eligible) begin
          mem_addr = host_addr;
          mem_we   = host_we;
        end
      end
      ST_STEP:   fetch_stall = 1'b0;
      ST_RESUME: fetch_stall = 1'b1;
      default:   fetch_stall = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= RST_STATE;
      host_ack    <= 1'b0;
      host_rdata  <= '0;
      steal_block <= 1'b0;
    end else begin
      host_ack    <= serve_rd || serve_wr;
      steal_block <= steal;
      if (serve_rd) begin
        host_rdata <= mem_rdata;
      end
      case (state)
        ST_RUN: begin
          if (halt_req) state <= ST_HALTED;
        end
        ST_HALTED: begin
          // a served host access wins; a coincident step pulse is lost
          if (!eligible) begin
            if (step_req)      state <= ST_STEP;
            else if (!halt_req) state <= ST_RESUME;
          end
        end
        ST_STEP:   state <= ST_HALTED;
        ST_RESUME: state <= halt_req ? ST_HALTED : ST_RUN;
        default:   state <= RST_STATE;
      endcase
    end
  end

endmodule

// File: tb/tb_dsp_imem_arbiter.sv
// tb/tb_dsp_imem_arbiter.sv - directed vector bench for dsp_imem_arbiter
module tb_dsp_imem_arbiter;

  logic        clk;
  logic        rst;
  logic [15:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        fetch_stall;
  logic        halt_req;
  logic        step_req;
  logic        halted;
  logic        host_req;
  logic        host_we;
  logic [15:0] host_addr;
  logic [31:0] host_wdata;
  logic        host_ack;
  logic [31:0] host_rdata;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] mem   [256];
  logic        mem_v [256];

  int checks = 0;
  int errors = 0;

  dsp_imem_arbiter #(.ADDR_W(16), .INST_W(32), .BOOT_HALTED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data), .fetch_stall(fetch_stall),
    .halt_req(halt_req), .step_req(step_req), .halted(halted),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // unwritten words read back as 0x1000_0000 + address
  assign mem_rdata = mem_v[mem_addr[7:0]] ? mem[mem_addr[7:0]] : (32'h1000_0000 + {16'h0, mem_addr});

  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 256; i++) mem_v[i] <= 1'b0;
    end else if (mem_we) begin
      mem[mem_addr[7:0]]   <= mem_wdata;
      mem_v[mem_addr[7:0]] <= 1'b1;
    end
  end

  typedef struct {
    logic        halt, step, hreq, hwe;
    logic [15:0] haddr;
    logic [31:0] hwdata;
    logic [15:0] faddr;
    logic        e_stall, e_halted, e_mwe;
    logic [15:0] e_maddr;
    logic        e_ack;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic h, logic s, logic rq, logic we, logic [15:0] ha,
                              logic [31:0] wd, logic [15:0] fa, logic es, logic eh,
                              logic ew, logic [15:0] ema, logic ea, logic [31:0] erd);
    vec_t v;
    v.halt = h; v.step = s; v.hreq = rq; v.hwe = we; v.haddr = ha; v.hwdata = wd;
    v.faddr = fa; v.e_stall = es; v.e_halted = eh; v.e_mwe = ew; v.e_maddr = ema;
    v.e_ack = ea; v.e_rdata = erd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  int          pc;
  int          advances;
  logic        prev_stall;
  logic [31:0] exp_rd;

  initial begin
    rst = 1'b0; halt_req = 1'b1; step_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    host_addr = '0; host_wdata = '0; fetch_addr = 16'h0010;

    @(negedge clk);
    chk("rst_halted", {31'h0, halted}, 32'd1);
    chk("rst_stall", {31'h0, fetch_stall}, 32'd1);
    chk("rst_ack", {31'h0, host_ack}, 32'd0);
    chk("rst_rdata", host_rdata, 32'd0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'h0, mem_addr}, 32'h10);
    next_cycle();
    rst = 1'b1;

    // halt step req we haddr wdata faddr | stall halted mwe maddr ack rdata
    vq.push_back(mk(1,0,1,1,16'h04,32'hABCD,16'h10, 1,1,1,16'h04,0,32'h0));
    vq.push_back(mk(1,0,1,1,16'h04,32'hABCD,16'h10, 1,1,0,16'h10,1,32'h0));
    vq.push_back(mk(1,0,1,0,16'h04,32'h0,   16'h10, 1,1,0,16'h04,0,32'h0));
    vq.push_back(mk(1,0,1,0,16'h04,32'h0,   16'h10, 1,1,0,16'h10,1,32'hABCD));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h10, 1,1,0,16'h10,0,32'hABCD));
    vq.push_back(mk(1,1,0,0,16'h00,32'h0,   16'h10, 1,1,0,16'h10,0,32'hABCD));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h11, 0,0,0,16'h11,0,32'hABCD));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h12, 1,1,0,16'h12,0,32'hABCD));
    vq.push_back(mk(1,1,1,0,16'h20,32'h0,   16'h12, 1,1,0,16'h20,0,32'hABCD));
    vq.push_back(mk(1,0,1,0,16'h20,32'h0,   16'h12, 1,1,0,16'h12,1,32'h1000_0020));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h12, 1,1,0,16'h12,0,32'h1000_0020));
    vq.push_back(mk(0,0,0,0,16'h00,32'h0,   16'h12, 1,1,0,16'h12,0,32'h1000_0020));
    vq.push_back(mk(0,0,0,0,16'h00,32'h0,   16'h30, 1,0,0,16'h30,0,32'h1000_0020));
    vq.push_back(mk(0,0,0,0,16'h00,32'h0,   16'h31, 0,0,0,16'h31,0,32'h1000_0020));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk(0,0,1,1,16'h08,32'h5555,16'h31, 0,0,0,16'h31,0,32'h1000_0020));
    vq.push_back(mk(1,0,1,1,16'h08,32'h5555,16'h31, 0,0,0,16'h31,0,32'h1000_0020));
    vq.push_back(mk(1,0,1,1,16'h08,32'h5555,16'h31, 1,1,1,16'h08,0,32'h1000_0020));
    vq.push_back(mk(1,0,1,1,16'h08,32'h5555,16'h31, 1,1,0,16'h31,1,32'h1000_0020));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h31, 1,1,0,16'h31,0,32'h1000_0020));
    vq.push_back(mk(0,0,0,0,16'h00,32'h0,   16'h31, 1,1,0,16'h31,0,32'h1000_0020));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h31, 1,0,0,16'h31,0,32'h1000_0020));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h31, 1,1,0,16'h31,0,32'h1000_0020));
    vq.push_back(mk(1,0,1,0,16'h08,32'h0,   16'h31, 1,1,0,16'h08,0,32'h1000_0020));
    vq.push_back(mk(1,0,0,0,16'h00,32'h0,   16'h31, 1,1,0,16'h31,1,32'h5555));

    foreach (vq[k]) begin
      halt_req = vq[k].halt; step_req = vq[k].step; host_req = vq[k].hreq;
      host_we = vq[k].hwe; host_addr = vq[k].haddr; host_wdata = vq[k].hwdata;
      fetch_addr = vq[k].faddr;
      @(negedge clk);
      chk($sformatf("v%0d_stall", k), {31'h0, fetch_stall}, {31'h0, vq[k].e_stall});
      chk($sformatf("v%0d_halted", k), {31'h0, halted}, {31'h0, vq[k].e_halted});
      chk($sformatf("v%0d_mem_we", k), {31'h0, mem_we}, {31'h0, vq[k].e_mwe});
      chk($sformatf("v%0d_mem_addr", k), {16'h0, mem_addr}, {16'h0, vq[k].e_maddr});
      chk($sformatf("v%0d_ack", k), {31'h0, host_ack}, {31'h0, vq[k].e_ack});
      chk($sformatf("v%0d_rdata", k), host_rdata, vq[k].e_rdata);
      next_cycle();
    end

    // leave HALTED: one HALTED cycle, one RESUME cycle, then RUN
    halt_req = 1'b0; host_req = 1'b0; host_we = 1'b0;
    next_cycle();
    next_cycle();

    // continuous host reads in RUN: steals alternate with fetch cycles
    pc = 16'h100; advances = 0; prev_stall = 1'b1;
    host_req = 1'b1; host_addr = 16'h40;
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && !prev_stall) begin
        pc++; advances++;
      end
      fetch_addr = pc[15:0];
      if (host_ack) begin
        exp_rd = 32'h1000_0000 + {16'h0, host_addr};
        chk($sformatf("steal%0d_rdata", i), host_rdata, exp_rd);
        host_addr = host_addr + 16'h1;
      end
      @(negedge clk);
      chk($sformatf("steal%0d_stall", i), {31'h0, fetch_stall}, (i % 2 == 0) ? 32'd1 : 32'd0);
      chk($sformatf("steal%0d_mem_addr", i), {16'h0, mem_addr},
          (i % 2 == 0) ? {16'h0, host_addr} : pc);
      prev_stall = fetch_stall;
      next_cycle();
    end
    if (!prev_stall) advances++;
    chk("steal_pc_advances", advances, 32'd4);
    chk("steal_reads_done", {16'h0, host_addr}, 32'h44);

    // halt requested in the same cycle as a steal: the steal still completes
    host_addr = 16'h50; halt_req = 1'b1;
    @(negedge clk);
    chk("halt_steal_stall", {31'h0, fetch_stall}, 32'd1);
    chk("halt_steal_addr", {16'h0, mem_addr}, 32'h50);
    chk("halt_steal_halted", {31'h0, halted}, 32'd0);
    next_cycle();
    @(negedge clk);
    chk("halt_steal_now_halted", {31'h0, halted}, 32'd1);
    chk("halt_steal_ack", {31'h0, host_ack}, 32'd1);
    chk("halt_steal_rdata", host_rdata, 32'h1000_0050);
    chk("halt_steal_no_we", {31'h0, mem_we}, 32'd0);
    next_cycle();

    // back to RUN, then reset while an ack is high
    host_req = 1'b0; halt_req = 1'b0;
    next_cycle();
    next_cycle();
    host_req = 1'b1; host_addr = 16'h60;
    @(negedge clk);
    chk("rst_steal_stall", {31'h0, fetch_stall}, 32'd1);
    chk("rst_steal_halted", {31'h0, halted}, 32'd0);
    next_cycle();
    chk("rst_steal_ack_pre", {31'h0, host_ack}, 32'd1);
    chk("rst_steal_rdata_pre", host_rdata, 32'h1000_0060);
    rst = 1'b0;
    #1;
    chk("async_rst_ack", {31'h0, host_ack}, 32'd0);
    chk("async_rst_halted", {31'h0, halted}, 32'd1);
    chk("async_rst_stall", {31'h0, fetch_stall}, 32'd1);
    chk("async_rst_rdata", host_rdata, 32'd0);
    chk("async_rst_mem_we", {31'h0, mem_we}, 32'd0);
    host_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
